// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: DATA_BITS payload LSB-first, optional even/odd parity,
// one or two stop bits, and a one-entry holding buffer so queued frames follow with no idle gap.
module uart_tx_cfg #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter int CNT_W      = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 b_tick,
   input  logic                 tx_valid,
   input  logic [DATA_BITS-1:0] tx_data,
   output logic                 tx_ready,
   input  logic [1:0]           parity_mode,
   input  logic                 two_stop,
   output logic                 tx,
   output logic                 tx_busy,
   output logic                 frame_done,
   output logic [2:0]           dbg_state
);

   localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ALIGN  = 3'd1,
      S_START  = 3'd2,
      S_DATA   = 3'd3,
      S_PARITY = 3'd4,
      S_STOP   = 3'd5
   } state_e;

   state_e               state_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [IDX_W-1:0]     idx_q;
   logic [DATA_BITS-1:0] shift_q;
   logic [DATA_BITS-1:0] buf_data_q;
   logic                 buf_full_q;
   logic                 par_en_q;
   logic                 par_bit_q;
   logic                 two_stop_q;
   logic                 stop2_q;
   logic                 tx_q;
   logic                 busy_q;
   logic                 frame_done_q;

   logic accept;
   logic bit_end;
   logic par_en_w;
   logic par_bit_w;

   // Handshake: a word moves into the buffer on any clk edge where tx_valid && tx_ready.
   assign accept    = tx_valid && !buf_full_q;
   assign bit_end   = b_tick && (cnt_q == CNT_W'(OVERSAMPLE - 1));
   assign par_en_w  = (parity_mode == 2'b01) || (parity_mode == 2'b10);
   assign par_bit_w = (^buf_data_q) ^ (parity_mode == 2'b10);

   assign tx_ready   = !buf_full_q;
   assign tx         = tx_q;
   assign tx_busy    = busy_q;
   assign frame_done = frame_done_q;
   assign dbg_state  = state_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         idx_q        <= '0;
         shift_q      <= '0;
         buf_data_q   <= '0;
         buf_full_q   <= 1'b0;
         par_en_q     <= 1'b0;
         par_bit_q    <= 1'b0;
         two_stop_q   <= 1'b0;
         stop2_q      <= 1'b0;
         tx_q         <= 1'b1;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         frame_done_q <= 1'b0;
         busy_q       <= 1'b1;
         if (accept) begin
            buf_full_q <= 1'b1;
            buf_data_q <= tx_data;
         end

         // tx follows the registered state, giving a fixed one-clk lag behind b_tick.
         case (state_q)
            S_START:  tx_q <= 1'b0;
            S_DATA:   tx_q <= shift_q[0];
            S_PARITY: tx_q <= par_bit_q;
            default:  tx_q <= 1'b1;
         endcase

         if ((state_q == S_START || state_q == S_DATA || state_q == S_PARITY ||
              state_q == S_STOP) && b_tick) begin
            cnt_q <= bit_end ? '0 : cnt_q + 1'b1;
         end

         case (state_q)
            S_IDLE: begin
               if (buf_full_q) begin
                  shift_q    <= buf_data_q;
                  par_en_q   <= par_en_w;
                  par_bit_q  <= par_bit_w;
                  two_stop_q <= two_stop;
                  buf_full_q <= 1'b0;
                  state_q    <= S_ALIGN;
               end else begin
                  busy_q <= accept;
               end
            end
            S_ALIGN: begin
               if (b_tick) begin
                  cnt_q   <= '0;
                  state_q <= S_START;
               end
            end
            S_START: begin
               if (bit_end) begin
                  idx_q   <= '0;
                  state_q <= S_DATA;
               end
            end
            S_DATA: begin
               if (bit_end) begin
                  shift_q <= shift_q >> 1;
                  if (idx_q == IDX_W'(DATA_BITS - 1)) begin
                     idx_q   <= '0;
                     state_q <= par_en_q ? S_PARITY : S_STOP;
                  end else begin
                     idx_q <= idx_q + 1'b1;
                  end
               end
            end
            S_PARITY: begin
               if (bit_end) state_q <= S_STOP;
            end
            S_STOP: begin
               if (bit_end) begin
                  if (two_stop_q && !stop2_q) begin
                     stop2_q <= 1'b1;
                  end else begin
                     stop2_q      <= 1'b0;
                     frame_done_q <= 1'b1;
                     // Already on the baud grid, so a buffered word skips ALIGN.
                     if (buf_full_q) begin
                        shift_q    <= buf_data_q;
                        par_en_q   <= par_en_w;
                        par_bit_q  <= par_bit_w;
                        two_stop_q <= two_stop;
                        buf_full_q <= 1'b0;
                        state_q    <= S_START;
                     end else begin
                        busy_q  <= accept;
                        state_q <= S_IDLE;
                     end
                  end
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= buf_full_q || accept;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: words queued with their frame config, serial line decoded at bit centres
// and compared against frames built from the UART framing rules.
module tb_uart_tx_cfg;

   localparam int DB = 8;
   localparam int OS = 16;
   localparam int P  = 4;
   localparam int T  = OS * P;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          b_tick = 1'b0;
   logic          tx_valid = 1'b0;
   logic [DB-1:0] tx_data = '0;
   logic [1:0]    parity_mode = 2'b00;
   logic          two_stop = 1'b0;
   logic          tx_ready;
   logic          tx;
   logic          tx_busy;
   logic          frame_done;
   logic [2:0]    dbg_state;

   // {two_stop, parity_mode, data}
   logic [DB+2:0] exp_q[$];

   int n_checks = 0;
   int n_fail   = 0;
   int fd_cnt   = 0;
   int b2b_cnt  = 0;
   int mon_bit  = -1;
   bit mon_busy = 1'b0;

   uart_tx_cfg #(.DATA_BITS(DB), .OVERSAMPLE(OS), .CNT_W(5)) dut (
      .clk(clk), .rst(rst), .b_tick(b_tick), .tx_valid(tx_valid), .tx_data(tx_data),
      .tx_ready(tx_ready), .parity_mode(parity_mode), .two_stop(two_stop), .tx(tx),
      .tx_busy(tx_busy), .frame_done(frame_done), .dbg_state(dbg_state)
   );

   // ---------------- clock / reset / baud tick ----------------
   initial forever #5 clk = ~clk;

   initial begin
      int c;
      c = 0;
      forever begin
         @(negedge clk);
         b_tick = (c == P - 1);
         c = (c + 1) % P;
      end
   end

   initial forever begin
      @(negedge clk);
      if (frame_done) fd_cnt++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic offer(input logic [DB-1:0] d);
      int n;
      n = 0;
      @(negedge clk);
      tx_valid = 1'b1;
      tx_data  = d;
      while (!tx_ready && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("accept_timeout", n < 3000, 1);
      exp_q.push_back({two_stop, parity_mode, d});
      @(negedge clk);
      tx_valid = 1'b0;
      check("ready_drop", tx_ready, 0);
   endtask

   task automatic wait_unload(output int n);
      n = 0;
      while (!tx_ready && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("unload_timeout", n < 3000, 1);
   endtask

   task automatic send(input logic [DB-1:0] d);
      int n;
      offer(d);
      wait_unload(n);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || mon_busy || tx_busy || !tx_ready) && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check("idle_timeout", n < 5000, 1);
   endtask

   // ---------------- monitor / scoreboard ----------------
   task automatic wait_n(input int n, output bit ab);
      ab = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (!rst) begin
            ab = 1'b1;
            return;
         end
      end
   endtask

   task automatic run_frames();
      bit            more;
      bit            ab;
      logic [DB+2:0] item;
      logic [DB-1:0] d;
      logic          lv[0:15];
      int            nb;
      int            ones;
      int            fd0;
      more = 1'b1;
      while (more) begin
         more = 1'b0;
         check("frame_expected", exp_q.size() != 0, 1);
         if (exp_q.size() == 0) return;
         item = exp_q.pop_front();
         d    = item[DB-1:0];
         ones = $countones(d);
         nb = 0;
         lv[nb] = 1'b0; nb++;
         for (int i = 0; i < DB; i++) begin
            lv[nb] = d[i]; nb++;
         end
         if (item[DB+1:DB] == 2'b01) begin
            lv[nb] = (ones % 2 == 1); nb++;
         end else if (item[DB+1:DB] == 2'b10) begin
            lv[nb] = (ones % 2 == 0); nb++;
         end
         lv[nb] = 1'b1; nb++;
         if (item[DB+2]) begin
            lv[nb] = 1'b1; nb++;
         end
         fd0 = fd_cnt;
         mon_busy = 1'b1;
         for (int k = 0; k < nb; k++) begin
            wait_n((k == 0) ? T / 2 : T, ab);
            if (ab) begin
               mon_busy = 1'b0;
               mon_bit  = -1;
               return;
            end
            mon_bit = k;
            check($sformatf("bit%0d_of_%02h", k, d), tx, lv[k]);
            check("busy_in_frame", tx_busy, 1);
         end
         wait_n(T / 2, ab);
         mon_bit = -1;
         if (ab) begin
            mon_busy = 1'b0;
            return;
         end
         check("frame_done_pulses", fd_cnt - fd0, 1);
         if (!tx) begin
            more = 1'b1;
            b2b_cnt++;
            check("busy_between_frames", tx_busy, 1);
         end
      end
      mon_busy = 1'b0;
   endtask

   initial begin
      bit tx_last;
      tx_last = 1'b1;
      forever begin
         @(negedge clk);
         if (rst && tx_last && !tx) run_frames();
         tx_last = tx;
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int n;
      int b0;
      logic [DB-1:0] d;

      // Reset held with a word offered: nothing may be accepted.
      tx_valid = 1'b1;
      tx_data  = 8'hA5;
      repeat (5) @(negedge clk);
      check("rst_tx", tx, 1);
      check("rst_ready", tx_ready, 1);
      check("rst_busy", tx_busy, 0);
      check("rst_frame_done", frame_done, 0);
      rst = 1'b1;
      exp_q.push_back({two_stop, parity_mode, 8'hA5});
      @(negedge clk);
      check("accept_after_release", tx_ready, 0);
      check("busy_after_accept", tx_busy, 1);
      tx_valid = 1'b0;
      wait_unload(n);
      wait_idle();

      // Parity polarity on 0x07, two stop bits.
      parity_mode = 2'b01; two_stop = 1'b0; send(8'h07); wait_idle();
      parity_mode = 2'b10; send(8'h07); wait_idle();
      parity_mode = 2'b00; two_stop = 1'b1; send(8'h5A); wait_idle();
      parity_mode = 2'b11; two_stop = 1'b0; send(8'hF0); wait_idle();

      // Back-to-back: second word waits in the buffer and starts with no idle bit.
      parity_mode = 2'b00; two_stop = 1'b0;
      b0 = b2b_cnt;
      send(8'h55);
      offer(8'hC3);
      wait_unload(n);
      check("ready_low_while_buffered", n > 8 * T, 1);
      wait_idle();
      check("back_to_back", b2b_cnt - b0, 1);

      // Config change mid-frame only affects the next frame.
      send(8'h3C);
      n = 0;
      while (mon_bit != 2 && n < 2000) begin @(negedge clk); n++; end
      check("mid_frame_wait", n < 2000, 1);
      parity_mode = 2'b01;
      send(8'h3C);
      wait_idle();

      // Randomised frames, gaps and configs.
      for (int i = 0; i < 24; i++) begin
         d = DB'($urandom_range(0, 255));
         if ($urandom_range(0, 2) == 0) repeat ($urandom_range(0, 300)) @(negedge clk);
         send(d);
         parity_mode = 2'($urandom_range(0, 3));
         two_stop    = 1'($urandom_range(0, 1));
      end
      wait_idle();

      // Reset during data bit 3 with a word buffered.
      parity_mode = 2'b01; two_stop = 1'b1;
      send(8'h96);
      offer(8'h3C);
      n = 0;
      while (mon_bit != 4 && n < 2000) begin @(negedge clk); n++; end
      check("reach_data_bit3", n < 2000, 1);
      #1 rst = 1'b0;
      #1;
      check("abort_tx_high", tx, 1);
      check("abort_ready", tx_ready, 1);
      check("abort_busy", tx_busy, 0);
      repeat (3) @(negedge clk);
      exp_q.delete();
      rst = 1'b1;
      repeat (20) @(negedge clk);
      check("no_resume_tx", tx, 1);
      check("no_resume_busy", tx_busy, 0);
      send(8'hE1);
      wait_idle();

      check("queue_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #900000;
      n_fail++;
      n_checks++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised UART transmitter, successor to the fixed 8N1 transmitter in the stopwatch UART path.
- Serialises DATA_BITS-wide words LSB-first at 1/OVERSAMPLE of the shared baud-tick rate.
- Runtime-selectable parity (none/even/odd) and 1 or 2 stop bits.
- One-entry holding buffer with valid/ready handshake, so a queued frame follows the previous stop bit with no idle gap.

Parameters:
DATA_BITS, 8, payload width per frame; legal 5..9
OVERSAMPLE, 16, b_tick pulses per bit period; legal 4..32
CNT_W, 5, tick-counter width; must satisfy 2^CNT_W >= OVERSAMPLE

Ports:
clk  in  1  system clock; all state on rising edge
rst  in  1  asynchronous, active-low reset (asserted when 0)
b_tick  in  1  one-clk baud oversample pulse from the baud generator
tx_valid  in  1  producer has a word on tx_data
tx_data  in  DATA_BITS  word to send
tx_ready  out  1  holding buffer empty; a word is accepted when tx_valid&&tx_ready
parity_mode  in  2  00 none, 01 even, 10 odd, 11 treated as none
two_stop  in  1  0 = one stop bit, 1 = two stop bits
tx  out  1  serial line, idle high
tx_busy  out  1  frame in progress or word buffered
frame_done  out  1  one-clk pulse at the end of each frame's final stop bit

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, tx=1, tx_ready=1, tx_busy=0, frame_done=0; buffer, shift register, counters cleared.
  - Reset mid-frame aborts the frame; tx returns high immediately.
  - Nothing is resumed after reset release.
- Holding buffer:
  - Accept on tx_valid&&tx_ready. tx_ready drops the next cycle.
  - tx_ready returns high the cycle after the FSM unloads the buffer.
  - Simultaneous unload and new accept cannot occur, because tx_ready is low while the buffer is full.
- Frame config: parity_mode and two_stop are sampled at unload and held for that frame. Mid-frame changes affect only the next frame.
- Bit timing:
  - Tick counter counts b_tick pulses within each bit.
  - A bit ends on the b_tick where the counter == OVERSAMPLE-1; the counter then resets to 0.
  - Clocks without b_tick do not advance the counter.
- FSM states: IDLE, ALIGN, START, DATA, PARITY, STOP.
  - IDLE: tx=1. If the buffer is full: unload into the shift register, compute the parity bit (even = XOR of data; odd = its inverse), go to ALIGN.
  - ALIGN: wait for b_tick, clear the counter, go to START. This aligns the frame to the baud grid.
  - START: tx=0 for OVERSAMPLE ticks, then DATA with bit index 0.
  - DATA: tx=shift[0]. At each bit end, shift right and increment the index. After bit index DATA_BITS-1, go to PARITY if parity is enabled, else STOP.
  - PARITY: tx=parity bit for OVERSAMPLE ticks, then STOP.
  - STOP: tx=1 for OVERSAMPLE ticks (2*OVERSAMPLE if two_stop). At the end:
    - pulse frame_done;
    - if the buffer is full, unload it and go directly to START (no ALIGN, since already aligned), giving zero idle between frames;
    - else go to IDLE.
- tx is registered: it changes the clk after the state/counter transition, so there is a constant one-clk offset from b_tick.
- tx_busy = (state != IDLE) || buffer full. It is registered and falls on the cycle IDLE is entered with an empty buffer.
- Illegal or unreachable state encodings go to IDLE with tx=1.
- Frame length in bits = 1 + DATA_BITS + (parity?1:0) + (two_stop?2:1).

Test Plan:
- Reset: hold rst=0 with tx_valid=1 -> tx=1, tx_ready=1, tx_busy=0, no accept. Release -> accept occurs next cycle.
- 8N1, OVERSAMPLE=16, b_tick every 4 clk, send 0xA5 -> line 0,1,0,1,0,0,1,0,1,1. Each bit is 16 ticks (64 clk). One frame_done pulse.
- Parity: 0x07 with even -> parity bit 1; with odd -> parity bit 0. DATA_BITS=7 build with two_stop=1: frame 11 bits, stop high 32 ticks.
- Back-to-back: assert 0x55 then 0xC3 while the first is transmitting -> tx_ready low until unload. Start bit of 0xC3 begins on the tick after 0x55's stop ends (no idle bit). tx_busy stays high throughout.
- Config change: toggle parity_mode from 00 to 01 mid-frame -> current frame has no parity bit; next frame carries it.
- Reset mid-frame: assert rst=0 during DATA bit 3 -> tx=1 asynchronously, buffered word dropped. Next frame after release is well-formed.
